// File: rtl/instr_encoder.sv
// Streaming MIPS-32 encoder: one-hot op code plus operand fields in, packed
// machine word with a sequential word address out, through a 2-entry queue.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  // Handshake: a transfer happens on any rising edge where valid && ready are
  // both high; valid never waits on ready, and the payload must be held
  // stable while valid is high and ready is low.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_code,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [15:0]       err_count
);

  logic              valid_code;
  logic [4:0]        idx;
  logic [11:0]       opfn;
  logic [31:0]       enc_word;
  logic [4:0]        rs_f, rt_f, rd_f, sh_f;
  logic              is_shift;

  logic [31:0]       q_instr [2];
  logic [ADDR_W-1:0] q_addr  [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic [1:0]        count_next;
  logic [ADDR_W-1:0] addr_ctr;
  logic              push, pop, bad;

  assign valid_code = !in_code[31] && (in_code[30:0] != 31'd0) &&
                      ((in_code[30:0] & (in_code[30:0] - 31'd1)) == 31'd0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < 31; i++) begin
      if (in_code[i]) idx = 5'(i);
    end
  end

  // {op, funct}; funct is only meaningful for the R-type rows.
  always_comb begin
    opfn = 12'b0;
    case (idx)
      5'd0:  opfn = {6'b000000, 6'b100000};
      5'd1:  opfn = {6'b000000, 6'b100001};
      5'd2:  opfn = {6'b000000, 6'b100010};
      5'd3:  opfn = {6'b000000, 6'b100011};
      5'd4:  opfn = {6'b000000, 6'b100100};
      5'd5:  opfn = {6'b000000, 6'b100101};
      5'd6:  opfn = {6'b000000, 6'b100110};
      5'd7:  opfn = {6'b000000, 6'b100111};
      5'd8:  opfn = {6'b000000, 6'b101010};
      5'd9:  opfn = {6'b000000, 6'b101011};
      5'd10: opfn = {6'b000000, 6'b000000};
      5'd11: opfn = {6'b000000, 6'b000010};
      5'd12: opfn = {6'b000000, 6'b000011};
      5'd13: opfn = {6'b000000, 6'b000100};
      5'd14: opfn = {6'b000000, 6'b000110};
      5'd15: opfn = {6'b000000, 6'b000111};
      5'd16: opfn = {6'b000000, 6'b001000};
      5'd17: opfn = {6'b001000, 6'b000000};
      5'd18: opfn = {6'b001001, 6'b000000};
      5'd19: opfn = {6'b001100, 6'b000000};
      5'd20: opfn = {6'b001101, 6'b000000};
      5'd21: opfn = {6'b001110, 6'b000000};
      5'd22: opfn = {6'b100011, 6'b000000};
      5'd23: opfn = {6'b101011, 6'b000000};
      5'd24: opfn = {6'b000100, 6'b000000};
      5'd25: opfn = {6'b000101, 6'b000000};
      5'd26: opfn = {6'b001010, 6'b000000};
      5'd27: opfn = {6'b001011, 6'b000000};
      5'd28: opfn = {6'b001111, 6'b000000};
      5'd29: opfn = {6'b000010, 6'b000000};
      5'd30: opfn = {6'b000011, 6'b000000};
      default: opfn = 12'b0;
    endcase
  end

  assign is_shift = (idx >= 5'd10) && (idx <= 5'd12);

  always_comb begin
    enc_word = '0;
    rs_f     = in_rs;
    rt_f     = in_rt;
    rd_f     = in_rd;
    sh_f     = '0;
    if (idx <= 5'd16) begin
      if (is_shift) begin
        rs_f = '0;
        sh_f = in_shamt;
      end
      if (idx == 5'd16) begin
        rt_f = '0;
        rd_f = '0;
      end
      enc_word = {6'b000000, rs_f, rt_f, rd_f, sh_f, opfn[5:0]};
    end else if (idx <= 5'd28) begin
      enc_word = {opfn[11:6], (idx == 5'd28) ? 5'd0 : in_rs, in_rt, in_imm};
    end else begin
      enc_word = {opfn[11:6], in_target};
    end
  end

  assign push       = in_valid && in_ready && valid_code;
  assign bad        = in_valid && in_ready && !valid_code;
  assign pop        = out_valid && out_ready;
  assign wr_ptr     = rd_ptr ^ count[0];
  assign count_next = count + {1'b0, push} - {1'b0, pop};

  assign out_valid = (count != 2'd0);
  assign out_instr = q_instr[rd_ptr];
  assign out_addr  = q_addr[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      q_instr[0] <= '0;
      q_instr[1] <= '0;
      q_addr[0]  <= '0;
      q_addr[1]  <= '0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      in_ready   <= 1'b0;
      addr_ctr   <= ADDR_W'(BASE_ADDR);
      err_valid  <= 1'b0;
      err_count  <= '0;
    end else begin
      if (push) begin
        q_instr[wr_ptr] <= enc_word;
        q_addr[wr_ptr]  <= addr_ctr;
        addr_ctr        <= addr_ctr + ADDR_W'(1);
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count     <= count_next;
      // Registered ready: reflects occupancy after this edge only.
      in_ready  <= (count_next < 2'd2);
      err_valid <= bad;
      if (bad && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: randomized and directed requests, expected words
// queued at issue time and compared by an independent output monitor.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready_s;
  logic [31:0] in_code = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        out_valid, out_valid_s;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_instr_s;
  logic [9:0]  out_addr;
  logic [1:0]  out_addr_s;
  logic        err_valid, err_valid_s;
  logic [15:0] err_count, err_count_s;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err_valid(err_valid), .err_count(err_count)
  );

  // Narrow-address instance shares the stimulus to exercise wrap-around.
  instr_encoder #(.ADDR_W(2), .BASE_ADDR(2)) u_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_code(in_code), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_instr(out_instr_s),
    .out_addr(out_addr_s), .err_valid(err_valid_s), .err_count(err_count_s)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [43:0] exp_q[$];
  logic [9:0]  ctr;
  logic [1:0]  ctr_s;
  int          err_total;
  bit          err_sched = 0;
  bit          err_expect = 0;
  bit          rnd_on = 0;

  int fn_tab[17] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7, 8};
  int op_tab[14] = '{8, 9, 12, 13, 14, 35, 43, 4, 5, 10, 11, 15, 2, 3};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_enc(input int k, input logic [4:0] rs, rt, rd, sh,
                                          input logic [15:0] imm, input logic [25:0] tgt);
    int w;
    if (k <= 16) begin
      bit shift_op = (k == 10 || k == 11 || k == 12);
      bit jr_op    = (k == 16);
      w = ((shift_op ? 0 : int'(rs)) << 21) + ((jr_op ? 0 : int'(rt)) << 16) +
          ((jr_op ? 0 : int'(rd)) << 11) + ((shift_op ? int'(sh) : 0) << 6) + fn_tab[k];
    end else if (k <= 28) begin
      w = (op_tab[k-17] << 26) + ((k == 28 ? 0 : int'(rs)) << 21) + (int'(rt) << 16) + int'(imm);
    end else begin
      w = (op_tab[k-17] << 26) + int'(tgt);
    end
    return 32'(w);
  endfunction

  task automatic send(input logic [31:0] code, input logic [4:0] rs, rt, rd, sh,
                      input logic [15:0] imm, input logic [25:0] tgt,
                      input bit use_exp, input logic [31:0] exp_word);
    int waited = 0;
    int k = 0;
    bit ok;
    in_code = code; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_target = tgt; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      ok = ($countones(code[30:0]) == 1) && !code[31];
      for (int i = 0; i < 31; i++) if (code[i]) k = i;
      if (ok) begin
        exp_q.push_back({use_exp ? exp_word : ref_enc(k, rs, rt, rd, sh, imm, tgt), ctr, ctr_s});
        ctr   = ctr + 10'd1;
        ctr_s = ctr_s + 2'd1;
      end else begin
        err_sched = 1;
        if (err_total < 65535) err_total++;
      end
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    ctr = 10'd0;
    ctr_s = 2'd2;
    err_total = 0;
    err_sched = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", {22'd0, out_addr}, 32'd0);
    chk("rst_err_valid", {31'd0, err_valid}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("rst_in_ready_high", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    err_expect = err_sched && !rst;
    err_sched  = 0;
  end

  bit          hold_v = 0;
  logic [31:0] hold_i;
  logic [9:0]  hold_a;
  logic [43:0] e;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("hold_instr", out_instr, hold_i);
        chk("hold_addr", {22'd0, out_addr}, {22'd0, hold_a});
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          chk("out_instr", out_instr, e[43:12]);
          chk("out_addr", {22'd0, out_addr}, {22'd0, e[11:2]});
          chk("out_addr_small", {30'd0, out_addr_s}, {30'd0, e[1:0]});
        end
      end
      hold_v = out_valid && !out_ready;
      hold_i = out_instr;
      hold_a = out_addr;
      chk("err_valid", {31'd0, err_valid}, {31'd0, err_expect});
    end
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] code;
    do_reset();
    out_ready = 1'b1;

    // Directed encodings with literal expected words.
    send(32'd1 << 0,  5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1, 32'h00221820);
    send(32'd1 << 10, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1, 32'h00011100);
    send(32'd1 << 17, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1, 32'h2022FFFF);
    send(32'd1 << 28, 5'd5, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0, 1, 32'h3C011234);
    send(32'd1 << 29, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100, 1, 32'h08000100);
    send(32'd1 << 30, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100, 1, 32'h0C000100);
    drain();

    // Backpressure: third request must stall until the consumer drains.
    do_reset();
    out_ready = 1'b0;
    fork
      begin
        send(32'd1 << 2,  5'd3, 5'd4, 5'd5, 5'd1, 16'h0, 26'h0, 0, 32'h0);
        send(32'd1 << 22, 5'd6, 5'd7, 5'd0, 5'd0, 16'h8000, 26'h0, 0, 32'h0);
        send(32'd1 << 16, 5'd9, 5'd8, 5'd7, 5'd6, 16'h0, 26'h0, 0, 32'h0);
      end
    join_none
    repeat (4) @(negedge clk);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_accepted", exp_q.size(), 32'd2);
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait fork;
    drain();

    // Invalid codes: pulses, count, no output, address unchanged.
    do_reset();
    send(32'h00000000, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 0, 32'h0);
    send(32'h00000003, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 0, 32'h0);
    send(32'h80000000, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 0, 32'h0);
    repeat (2) @(negedge clk);
    chk("err_count_3", {16'd0, err_count}, 32'd3);
    chk("err_count_small", {16'd0, err_count_s}, 32'd3);
    @(posedge clk);
    #2;
    send(32'd1 << 5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 0, 32'h0);
    drain();

    // Reset with a full queue.
    out_ready = 1'b0;
    send(32'd1 << 19, 5'd1, 5'd2, 5'd0, 5'd0, 16'h00FF, 26'h0, 0, 32'h0);
    send(32'd1 << 24, 5'd3, 5'd4, 5'd0, 5'd0, 16'hFFFE, 26'h0, 0, 32'h0);
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    do_reset();
    out_ready = 1'b1;
    send(32'd1 << 13, 5'd1, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 0, 32'h0);
    drain();

    // Random traffic with random consumer stalls.
    rnd_on = 1;
    fork
      while (rnd_on) begin
        @(posedge clk);
        #2;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 8) code = 32'd1 << $urandom_range(0, 30);
      else code = $urandom;
      send(code, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           16'($urandom), 26'($urandom), 0, 32'h0);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #2;
      end
    end
    rnd_on = 0;
    @(posedge clk);
    #3;
    out_ready = 1'b1;
    drain();
    repeat (2) @(negedge clk);
    chk("err_count_final", {16'd0, err_count}, 32'(err_total));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming MIPS-32 instruction encoder. It accepts the CPU's 31-op one-hot instruction code plus operand fields and produces the packed 32-bit machine word. It stamps each word with a sequential instruction-memory word address and buffers results in a 2-entry output queue with valid/ready backpressure. It sits in the IMEM loader / self-test path and feeds the instruction memory, whose words the CPU's one-hot instruction decoder later consumes.

## Interface
- ADDR_W, 10, width of the output word address; the address wraps modulo 2^ADDR_W.
- BASE_ADDR, 0, address assigned to the first valid instruction after reset.

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept (registered)
- in_code  in  32  one-hot op code (bit map below)
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_imm  in  16  I-type immediate
- in_target  in  26  J-type target
- out_valid  out  1  out_instr/out_addr valid
- out_ready  in  1  consumer accepts
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  word address for out_instr
- err_valid  out  1  one-cycle pulse: an invalid code was consumed
- err_count  out  16  invalid-code count, saturates at 0xFFFF

## Operation
- Bit map, as {op,funct} in binary:
  - 0 add 100000; 1 addu 100001; 2 sub 100010; 3 subu 100011; 4 and 100100; 5 or 100101
  - 6 xor 100110; 7 nor 100111; 8 slt 101010; 9 sltu 101011; 10 sll 000000; 11 srl 000010
  - 12 sra 000011; 13 sllv 000100; 14 srlv 000110; 15 srav 000111; 16 jr 001000
  - These R-type ops use op=000000 and the funct shown.
  - I-type ops, op shown: 17 addi 001000; 18 addiu 001001; 19 andi 001100; 20 ori 001101; 21 xori 001110; 22 lw 100011; 23 sw 101011; 24 beq 000100; 25 bne 000101; 26 slti 001010; 27 sltiu 001011; 28 lui 001111.
  - J-type ops, op shown: 29 j 000010; 30 jal 000011.
  - Bit 31 is reserved.
- R-type word: {000000, rs, rt, rd, shamt, funct}.
  - shamt is forced to 0 except for sll/srl/sra.
  - rs is forced to 0 for sll/srl/sra.
  - rt, rd and shamt are forced to 0 for jr.
- I-type word: {op, rs, rt, imm}; rs is forced to 0 for lui.
- J-type word: {op, target}.
- Valid code: exactly one of bits 0..30 set and bit 31 clear. Anything else is invalid.
- Transfer: occurs when in_valid && in_ready.
  - Valid code: the encoded word is pushed with out_addr = addr_ctr, then addr_ctr increments and wraps from 2^ADDR_W-1 to 0.
  - Invalid code: nothing is pushed and addr_ctr is unchanged; err_valid pulses the next cycle and err_count increments (saturating).
- Queue: 2 entries, FIFO order.
  - The head drives out_instr/out_addr.
  - Pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle is legal; the occupancy stays the same.
- in_ready is registered and equals 1 when the occupancy after the current edge is < 2.
  - A pop in the cycle the queue reaches full does not raise in_ready until the following cycle.
- Input fields are sampled only on a transfer. Holding in_valid without in_ready has no effect.

## Timing
- Reset (rst=1 at an edge) sets:
  - in_ready=0, out_valid=0, out_instr=0, out_addr=0
  - err_valid=0, err_count=0, addr_ctr=BASE_ADDR
  - queue occupancy=0
- in_ready=1 at the first edge with rst=0.
- Reset mid-operation discards all queued words and in-flight requests. No partial outputs appear.
- Latency:
  - A transfer at edge N gives out_valid=1 with that word after edge N (same cycle as err_valid for invalid codes).
  - A word may pop at edge N+1.
- Throughput: 1 word/cycle with out_ready held high.
- out_instr/out_addr are stable while out_valid=1 and out_ready=0.
- err_valid is high for exactly one cycle per invalid transfer. Back-to-back invalid transfers give consecutive pulses.

## Test plan
- Reset, then add rs=1 rt=2 rd=3 -> out_instr=0x00221820, out_addr=0. Then sll rs=7 rt=1 rd=2 shamt=4 -> 0x00011100, out_addr=1.
- Encoding checks:
  - addi rs=1 rt=2 imm=0xFFFF -> 0x2022FFFF
  - lui rs=5 rt=1 imm=0x1234 -> 0x3C011234
  - j target=0x100 -> 0x08000100
  - jal target=0x100 -> 0x0C000100
- Backpressure: out_ready=0, offer 3 valid ops back-to-back.
  - The first 2 are accepted; in_ready=0 and the 3rd is held.
  - Raise out_ready: all 3 emerge in order at addrs 0,1,2, and no word is dropped or duplicated.
- in_code=0x00000000, then 0x00000003, then 0x80000000 -> three err_valid pulses, err_count=3, no out_valid, next valid op gets out_addr=0.
- ADDR_W=2, BASE_ADDR=2, five valid ops -> out_addr 2,3,0,1,2.
- Queue full and rst=1 for one cycle -> out_valid=0, err_count=0, in_ready=0 then 1; next op gets out_addr=BASE_ADDR.
